// File: rtl/fc_tx_credit_gate_if.sv
// Credit-word and TLP-request channels between the link layer and the credit gate.
// The master drives FC words and requests; the slave (gate) returns ready.
interface fc_tx_credit_gate_if #(
  parameter int CREDIT_WIDTH = 8
);
  logic                      fc_valid;
  logic                      fc_init;
  logic [CREDIT_WIDTH+2:0]   fc_word;
  logic                      tlp_req_valid;
  logic [CREDIT_WIDTH-1:0]   tlp_req_credits;
  logic                      tlp_req_ready;

  modport master (
    output fc_valid, fc_init, fc_word, tlp_req_valid, tlp_req_credits,
    input  tlp_req_ready
  );

  modport slave (
    input  fc_valid, fc_init, fc_word, tlp_req_valid, tlp_req_credits,
    output tlp_req_ready
  );
endinterface

// File: rtl/fc_tx_credit_gate.sv
// TX credit gate for one FC type: tracks CL/CC with modular arithmetic, InitFC value 0 = infinite.
// Ready is combinational from registers and the current request; new CL is seen one cycle after fc_valid.
module fc_tx_credit_gate #(
  parameter int         CREDIT_WIDTH = 8,
  parameter logic [2:0] BUFFER_TYPE  = 3'b000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fc_tx_credit_gate_if.slave       bus,
  output logic                     fc_active,
  output logic                     credit_infinite,
  output logic [CREDIT_WIDTH-1:0]  credits_available,
  output logic                     protocol_error
);

  typedef logic [CREDIT_WIDTH-1:0] credit_t;

  typedef struct packed {
    logic [2:0] fc_type;
    credit_t    value;
  } fc_word_t;

  typedef enum logic {
    INIT_WAIT = 1'b0,
    ACTIVE    = 1'b1
  } state_t;

  localparam credit_t HALF = {1'b1, {(CREDIT_WIDTH-1){1'b0}}};

  state_t   state_q, state_d;
  credit_t  cl_q, cl_d;
  credit_t  cc_q, cc_d;
  logic     inf_q, inf_d;
  logic     err_q, err_d;

  fc_word_t word;
  logic     type_hit;
  credit_t  upd_gap;
  credit_t  room;
  logic     ready;

  assign word     = bus.fc_word;
  assign type_hit = bus.fc_valid && (word.fc_type == BUFFER_TYPE);

  // Both differences use pre-edge register values, so a same-cycle update
  // is judged against CC before the accept and ready sees the old CL.
  assign upd_gap  = word.value - cc_q;
  assign room     = cl_q - (cc_q + bus.tlp_req_credits);

  always_comb begin
    state_d = state_q;
    cl_d    = cl_q;
    cc_d    = cc_q;
    inf_d   = inf_q;
    err_d   = err_q;
    ready   = 1'b0;

    case (state_q)
      INIT_WAIT: begin
        if (type_hit && bus.fc_init) begin
          cl_d    = word.value;
          cc_d    = '0;
          inf_d   = (word.value == '0);
          state_d = ACTIVE;
        end
      end

      ACTIVE: begin
        // Zero-credit requests pass even when a large InitFC leaves CL-CC above half range.
        ready = inf_q || (bus.tlp_req_credits == '0) || (room <= HALF);

        if (type_hit && !bus.fc_init && !inf_q) begin
          if (upd_gap > HALF) begin
            err_d = 1'b1;
          end else begin
            cl_d = word.value;
          end
        end

        if (bus.tlp_req_valid && ready && !inf_q) begin
          cc_d = cc_q + bus.tlp_req_credits;
        end
      end

      default: begin
        state_d = INIT_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_WAIT;
      cl_q    <= '0;
      cc_q    <= '0;
      inf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cl_q    <= cl_d;
      cc_q    <= cc_d;
      inf_q   <= inf_d;
      err_q   <= err_d;
    end
  end

  assign bus.tlp_req_ready = ready;
  assign fc_active         = (state_q == ACTIVE);
  assign credit_infinite   = inf_q;
  assign protocol_error    = err_q;
  assign credits_available = (state_q != ACTIVE) ? '0 :
                             inf_q               ? '1 :
                                                   credit_t'(cl_q - cc_q);

endmodule

// File: tb/tb_fc_tx_credit_gate.sv
// Vector-table bench for fc_tx_credit_gate: rows hold inputs plus outputs expected in that cycle.
module tb_fc_tx_credit_gate;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fc_tx_credit_gate_if #(.CREDIT_WIDTH(W)) bus ();

  logic         fc_active;
  logic         credit_infinite;
  logic [W-1:0] credits_available;
  logic         protocol_error;

  fc_tx_credit_gate #(.CREDIT_WIDTH(W), .BUFFER_TYPE(3'b000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .fc_active         (fc_active),
    .credit_infinite   (credit_infinite),
    .credits_available (credits_available),
    .protocol_error    (protocol_error)
  );

  typedef struct {
    logic         rst;
    logic         fv;
    logic         fi;
    logic [2:0]   ft;
    logic [W-1:0] fval;
    logic         rv;
    logic [W-1:0] rc;
    logic         e_rdy;
    logic         e_act;
    logic         e_inf;
    logic [W-1:0] e_avail;
    logic         e_err;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(bit r, bit fv, bit fi, logic [2:0] ft, int fval,
                              bit rv, int rc, bit rdy, bit act, bit inf, int avail, bit err);
    vec_t v;
    v.rst = r;   v.fv = fv;  v.fi = fi;  v.ft = ft;  v.fval = W'(fval);
    v.rv = rv;   v.rc = W'(rc);
    v.e_rdy = rdy; v.e_act = act; v.e_inf = inf; v.e_avail = W'(avail); v.e_err = err;
    return v;
  endfunction

  function automatic void add(bit r, bit fv, bit fi, logic [2:0] ft, int fval,
                              bit rv, int rc, bit rdy, bit act, bit inf, int avail, bit err);
    tbl.push_back(mk(r, fv, fi, ft, fval, rv, rc, rdy, act, inf, avail, err));
  endfunction

  task automatic chk(input string name, input int row, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.fc_valid        = v.fv;
    bus.fc_init         = v.fi;
    bus.fc_word         = {v.ft, v.fval};
    bus.tlp_req_valid   = v.rv;
    bus.tlp_req_credits = v.rc;
  endtask

  task automatic check_out(input int row);
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty row=%0d got=0 want=1", row);
    end else begin
      e = sb.pop_front();
      chk("tlp_req_ready",     row, W'(bus.tlp_req_ready), W'(e.e_rdy));
      chk("fc_active",         row, W'(fc_active),         W'(e.e_act));
      chk("credit_infinite",   row, W'(credit_infinite),   W'(e.e_inf));
      chk("credits_available", row, credits_available,     e.e_avail);
      chk("protocol_error",    row, W'(protocol_error),    W'(e.e_err));
    end
  endtask

  task automatic step(input vec_t v, input int row);
    @(posedge clk);
    #1;
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    check_out(row);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    chk("rst_ready",  -1, W'(bus.tlp_req_ready), '0);
    chk("rst_active", -1, W'(fc_active),         '0);
    chk("rst_avail",  -1, credits_available,     '0);
    chk("rst_err",    -1, W'(protocol_error),    '0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // r fv fi type val  rv rc   rdy act inf avail err
    // InitFC 16, drain 16 singles, 17th stalls alongside UpdateFC 20.
    add(1, 1, 1, 3'b000, 16,  0, 0,   0, 0, 0, 0,  0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 16, 0);
    for (int k = 0; k < 16; k++)
      add(0, 0, 0, 3'b000, 0, 1, 1,   1, 1, 0, 16 - k, 0);
    add(0, 1, 0, 3'b000, 20,  1, 1,   0, 1, 0, 0,  0);
    add(0, 0, 0, 3'b000, 0,   1, 1,   1, 1, 0, 4,  0);
    add(0, 1, 0, 3'b010, 100, 0, 0,   1, 1, 0, 3,  0);
    add(0, 1, 1, 3'b000, 50,  0, 0,   1, 1, 0, 3,  0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 3,  0);
    // Wrap-around: CL=250, CC=250, UpdateFC 4.
    add(1, 1, 1, 3'b000, 250, 0, 0,   0, 0, 0, 0,   0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 250, 0);
    add(0, 0, 0, 3'b000, 0,   1, 250, 1, 1, 0, 250, 0);
    add(0, 1, 0, 3'b000, 4,   0, 0,   1, 1, 0, 0,   0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 10,  0);
    add(0, 0, 0, 3'b000, 0,   1, 8,   1, 1, 0, 10,  0);
    add(0, 0, 0, 3'b000, 0,   0, 3,   0, 1, 0, 2,   0);
    add(0, 0, 0, 3'b000, 0,   1, 2,   1, 1, 0, 2,   0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 0,   0);
    add(0, 0, 0, 3'b000, 0,   1, 1,   0, 1, 0, 0,   0);
    // Type filtering, INIT_WAIT UpdateFC, illegal update and stickiness.
    add(1, 1, 0, 3'b000, 40,  0, 0,   0, 0, 0, 0,  0);
    add(0, 1, 1, 3'b001, 16,  0, 0,   0, 0, 0, 0,  0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   0, 0, 0, 0,  0);
    add(0, 1, 1, 3'b000, 16,  0, 0,   0, 0, 0, 0,  0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 16, 0);
    add(0, 0, 0, 3'b000, 0,   1, 10,  1, 1, 0, 16, 0);
    add(0, 1, 0, 3'b000, 5,   0, 0,   1, 1, 0, 6,  0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 6,  1);
    add(0, 1, 0, 3'b000, 30,  0, 0,   1, 1, 0, 6,  1);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 20, 1);
    // Same-cycle accept + UpdateFC, then the half-range legality boundary.
    add(1, 1, 1, 3'b000, 16,  0, 0,   0, 0, 0, 0,   0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 16,  0);
    add(0, 0, 0, 3'b000, 0,   1, 15,  1, 1, 0, 16,  0);
    add(0, 1, 0, 3'b000, 24,  1, 1,   1, 1, 0, 1,   0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 8,   0);
    add(0, 1, 0, 3'b000, 144, 0, 0,   1, 1, 0, 8,   0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 128, 0);
    add(0, 1, 0, 3'b000, 145, 0, 0,   1, 1, 0, 128, 0);
    add(0, 0, 0, 3'b000, 0,   0, 0,   1, 1, 0, 128, 1);

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));

    // No FC words: a held request must never see ready.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(mk(0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 0, 0, 0), 1000 + i);
    step(mk(0, 1, 1, 3'b000, 16, 1, 1, 0, 0, 0, 0, 0), 1020);
    step(mk(0, 0, 0, 3'b000, 0,  1, 1, 1, 1, 0, 16, 0), 1021);
    // Asynchronous reset mid-cycle with a transfer pending.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready",  1022, W'(bus.tlp_req_ready), '0);
    chk("async_rst_active", 1022, W'(fc_active),         '0);
    chk("async_rst_avail",  1022, credits_available,     '0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i], i);
    end

    // Infinite credit: 1000 back-to-back 5-credit accepts, then an ignored UpdateFC.
    do_reset();
    step(mk(0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0,   0), 2000);
    step(mk(0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 1, 255, 0), 2001);
    for (int i = 0; i < 1000; i++)
      step(mk(0, 0, 0, 3'b000, 0, 1, 5, 1, 1, 1, 255, 0), 3000 + i);
    step(mk(0, 1, 0, 3'b000, 7, 0, 0, 1, 1, 1, 255, 0), 4000);
    step(mk(0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 1, 255, 0), 4001);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
